// File: rtl/uart_autobaud_ctrl_pkg.sv
// Shared constants and FSM state type for the UART auto-baud configurator.
package uart_autobaud_ctrl_pkg;

  localparam int unsigned BAUD_W       = 16;
  localparam int unsigned DEF_BAUD_DIV = 325;
  localparam int unsigned OVS_SHIFT    = 4;
  localparam int unsigned BITS_SHIFT   = 3;
  localparam int unsigned FRAME_FALLS  = 5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_IDLE = 3'd1,
    ST_WAIT_FALL = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_CALC      = 3'd4,
    ST_ERROR     = 3'd5
  } state_e;

endpackage

// File: rtl/uart_autobaud_ctrl_rx_sync.sv
// Two-flop Rx synchronizer followed by a registered falling-edge pulse.
module uart_autobaud_ctrl_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_i,
  output logic rx_sync_o,
  output logic fall_o
);

  // [0],[1] synchronizer stages, [2] previous synchronized value
  logic [2:0] sync_q;
  logic       fall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 3'b111;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], rx_i};
      fall_q <= sync_q[2] & ~sync_q[1];
    end
  end

  assign rx_sync_o = sync_q[1];
  assign fall_o    = fall_q;

endmodule

// File: rtl/uart_autobaud_ctrl.sv
// Auto-baud configurator: times eight bit periods of a 0x55 frame on Rx and
// drives the rounded 16x-oversample divisor onto BaudRate.
module uart_autobaud_ctrl
  import uart_autobaud_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned DEFAULT_DIV = DEF_BAUD_DIV,
  parameter int unsigned IDLE_CYCLES = 1024,
  parameter int unsigned MIN_DIV     = 2
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Rx,
  input  logic              Start,
  output logic [BAUD_W-1:0] BaudRate,
  output logic              BaudValid,
  output logic              Locked,
  output logic              Busy,
  output logic              Error
);

  localparam int unsigned DIV_SHIFT = OVS_SHIFT + BITS_SHIFT;
  localparam int unsigned CALC_W    = (CNT_W > BAUD_W) ? CNT_W + 1 : BAUD_W + 1;
  localparam int unsigned IDLE_W    = (IDLE_CYCLES > 2) ? $clog2(IDLE_CYCLES) : 1;

  logic rx_sync;
  logic rx_fall;

  state_e              state_q, state_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          edges_q, edges_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic                valid_q, valid_d;
  logic                locked_q, locked_d;
  logic                error_q, error_d;
  logic                busy_q, busy_d;

  logic [CALC_W-1:0]   quo_c;
  logic [BAUD_W-1:0]   div_c;

  uart_autobaud_ctrl_rx_sync u_rx_sync (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .rx_i      (Rx),
    .rx_sync_o (rx_sync),
    .fall_o    (rx_fall)
  );

  // Eight bit times divided by 8*16 with round-half-up, saturated to 16 bits
  always_comb begin
    quo_c = (CALC_W'(cnt_q) + CALC_W'(1 << (DIV_SHIFT - 1))) >> DIV_SHIFT;
    div_c = (quo_c > CALC_W'({BAUD_W{1'b1}})) ? {BAUD_W{1'b1}} : BAUD_W'(quo_c);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= ST_IDLE;
      idle_cnt_q <= '0;
      cnt_q      <= '0;
      edges_q    <= '0;
      baud_q     <= BAUD_W'(DEFAULT_DIV);
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      error_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      cnt_q      <= cnt_d;
      edges_q    <= edges_d;
      baud_q     <= baud_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      error_q    <= error_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    cnt_d      = cnt_q;
    edges_d    = edges_q;
    baud_d     = baud_q;
    valid_d    = 1'b0;
    locked_d   = locked_q;
    error_d    = error_q;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d    = ST_WAIT_IDLE;
          locked_d   = 1'b0;
          error_d    = 1'b0;
          idle_cnt_d = '0;
        end
      end
      ST_WAIT_IDLE: begin
        if (!rx_sync) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_W'(IDLE_CYCLES - 1)) begin
          state_d = ST_WAIT_FALL;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
      end
      ST_WAIT_FALL: begin
        if (rx_fall) begin
          state_d = ST_MEASURE;
          cnt_d   = '0;
          edges_d = 3'd1;
        end
      end
      ST_MEASURE: begin
        // A saturated counter means the line never produced the closing edge
        if (cnt_q == {CNT_W{1'b1}}) begin
          state_d = ST_ERROR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (rx_fall) begin
            edges_d = edges_q + 3'd1;
            if (edges_q == 3'(FRAME_FALLS - 1)) begin
              state_d = ST_CALC;
            end
          end
        end
      end
      ST_CALC: begin
        if (quo_c < CALC_W'(MIN_DIV)) begin
          state_d = ST_ERROR;
        end else begin
          baud_d   = div_c;
          valid_d  = 1'b1;
          locked_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_ERROR: begin
        error_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign BaudRate  = baud_q;
  assign BaudValid = valid_q;
  assign Locked    = locked_q;
  assign Busy      = busy_q;
  assign Error     = error_q;

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Bench for uart_autobaud_ctrl: lane A (CNT_W=24) runs the frame scenarios,
// lane B (CNT_W=12) runs the stuck-low overflow scenario in parallel.
module tb_uart_autobaud_ctrl;

  localparam int DEF = 325;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int errors = 0;
  int checks = 0;

  logic        rst_n_a, rx_a, start_a;
  logic [15:0] baud_a;
  logic        valid_a, locked_a, busy_a, error_a;

  logic        rst_n_b, rx_b, start_b;
  logic [15:0] baud_b;
  logic        valid_b, locked_b, busy_b, error_b;

  uart_autobaud_ctrl dut_a (
    .Clk       (clk),
    .Rst_n     (rst_n_a),
    .Rx        (rx_a),
    .Start     (start_a),
    .BaudRate  (baud_a),
    .BaudValid (valid_a),
    .Locked    (locked_a),
    .Busy      (busy_a),
    .Error     (error_a)
  );

  uart_autobaud_ctrl #(.CNT_W(12)) dut_b (
    .Clk       (clk),
    .Rst_n     (rst_n_b),
    .Rx        (rx_b),
    .Start     (start_b),
    .BaudRate  (baud_b),
    .BaudValid (valid_b),
    .Locked    (locked_b),
    .Busy      (busy_b),
    .Error     (error_b)
  );

  // Divisor a clean frame of bp cycles/bit must produce: 8 bits, /128, round half up.
  function automatic int exp_div(input int bp);
    int d;
    d = (8 * bp + 64) / 128;
    if (d > 65535) d = 65535;
    return d;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Lane A model: BaudRate may only move on a pulse that the bench expects
  int   exp_baud_a = DEF;
  int   pulses_a   = 0;
  int   t_valid_a  = 0;
  int   t_e5_a     = 0;
  logic pend_v     = 1'b0;
  int   pend_val   = 0;

  always @(negedge clk) begin
    if (!rst_n_a) begin
      exp_baud_a = DEF;
    end else if (valid_a) begin
      pulses_a++;
      t_valid_a = cyc_cnt;
      checks++;
      if (!pend_v) begin
        errors++;
        $display("FAIL valid_unexpected: pulse with BaudRate %0d where none is due", baud_a);
      end else begin
        exp_baud_a = pend_val;
      end
    end
    chk("a_baud_track", int'(baud_a), exp_baud_a);
  end

  // Lane B never locks, so BaudRate must sit at the default with no pulse
  always @(negedge clk) begin
    if (rst_n_b) begin
      chk("b_baud_track", int'(baud_b), DEF);
      chk("b_no_valid", int'(valid_b), 0);
    end
  end

  task automatic start_a_pulse();
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  // 0x55 frame LSB first: start, 1,0,1,0,1,0,1,0, stop. Index 8 is the fifth fall.
  task automatic frame_a(input int bp, input int lead, input bit mid_start);
    logic [9:0] bits;
    bits = 10'b1010101010;
    repeat (lead) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      rx_a = bits[i];
      if (i == 8) t_e5_a = cyc_cnt;
      if (mid_start && i == 3) begin
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (bp - 1) @(posedge clk);
      end else begin
        repeat (bp) @(posedge clk);
      end
      #1;
    end
  endtask

  task automatic lane_a();
    rst_n_a = 1'b0; rx_a = 1'b1; start_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_baud", int'(baud_a), 325);
    chk("rst_locked", int'(locked_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_error", int'(error_a), 0);
    rst_n_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // A fall driven after posedge k leaves k+2 synchronised-high cycles: 1023 -> rejected
    start_a_pulse();
    chk("t1_busy_after_start", int'(busy_a), 1);
    frame_a(434, 1021, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    chk("t1_short_idle_pulses", pulses_a, 0);
    chk("t1_short_idle_busy", int'(busy_a), 1);
    chk("t1_short_idle_locked", int'(locked_a), 0);

    // Same Start: after a long idle the next frame is measured
    pend_val = exp_div(434); pend_v = 1'b1;
    frame_a(434, 1100, 1'b0);
    pend_v = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("t1_pulses", pulses_a, 1);
    chk("t1_baud_115200", int'(baud_a), 27);
    chk("t1_locked", int'(locked_a), 1);
    chk("t1_busy", int'(busy_a), 0);
    chk_rng("t1_valid_latency", t_valid_a - t_e5_a, 4, 6);

    // Exactly 1024 synchronised-high cycles, with a Start mid-frame to be ignored
    start_a_pulse();
    chk("t3_locked_cleared", int'(locked_a), 0);
    pend_val = exp_div(434); pend_v = 1'b1;
    frame_a(434, 1022, 1'b1);
    pend_v = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("t3_pulses", pulses_a, 2);
    chk("t3_baud", int'(baud_a), 27);
    chk("t3_locked", int'(locked_a), 1);
    chk("t3_busy", int'(busy_a), 0);

    // 8 cycles/bit rounds to divisor 1: below the legal minimum
    start_a_pulse();
    frame_a(8, 1100, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    chk("t5_pulses", pulses_a, 2);
    chk("t5_error", int'(error_a), 1);
    chk("t5_locked", int'(locked_a), 0);
    chk("t5_busy", int'(busy_a), 0);
    chk("t5_baud_kept", int'(baud_a), 27);

    // Reset in the middle of a measurement
    start_a_pulse();
    chk("t6_error_cleared", int'(error_a), 0);
    repeat (1100) @(posedge clk);
    #1;
    rx_a = 1'b0;
    repeat (2000) @(posedge clk);
    #1;
    chk("t6_busy_pre_reset", int'(busy_a), 1);
    rst_n_a = 1'b0;
    #1;
    chk("t6_rst_baud", int'(baud_a), 325);
    chk("t6_rst_busy", int'(busy_a), 0);
    chk("t6_rst_locked", int'(locked_a), 0);
    chk("t6_rst_error", int'(error_a), 0);
    chk("t6_rst_valid", int'(valid_a), 0);
    rx_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Clean 9600-baud frame at 50 MHz: 5208 cycles/bit
    start_a_pulse();
    pend_val = exp_div(5208); pend_v = 1'b1;
    frame_a(5208, 1100, 1'b0);
    pend_v = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("t2_pulses", pulses_a, 3);
    chk("t2_baud_9600", int'(baud_a), 326);
    chk("t2_locked", int'(locked_a), 1);
    chk("t2_busy", int'(busy_a), 0);
    chk("t2_error", int'(error_a), 0);
    chk_rng("t2_valid_latency", t_valid_a - t_e5_a, 4, 6);
  endtask

  task automatic lane_b();
    int  t0;
    int  t_err;
    bit  found;
    rst_n_b = 1'b0; rx_b = 1'b1; start_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("b_rst_baud", int'(baud_b), 325);
    chk("b_rst_error", int'(error_b), 0);
    rst_n_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    repeat (1100) @(posedge clk);
    #1;
    rx_b = 1'b0;
    t0 = cyc_cnt;
    t_err = 0;
    found = 1'b0;
    // 12-bit counter runs out 4096 counts after the start bit is seen
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (error_b) begin
        found = 1'b1;
        t_err = cyc_cnt;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL b_error_timeout: Error still %0d after 6000 cycles, required 1", error_b);
    end else begin
      chk_rng("b_error_latency", t_err - t0, 4098, 4104);
    end
    chk("b_error_locked", int'(locked_b), 0);
    chk("b_error_busy", int'(busy_b), 0);
    chk("b_error_baud", int'(baud_b), 325);
    @(posedge clk); #1;
    rx_b = 1'b1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    chk("b_start_clears_error", int'(error_b), 0);
    chk("b_start_busy", int'(busy_b), 1);
  endtask

  initial begin
    fork
      lane_a();
      lane_b();
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc_cnt);
    $fatal(1, "watchdog expired");
  end

endmodule
